ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//   Receives the raw PS/2 keyboard clock/data pair and turns it into scan-code bytes.
//   Decodes make/break codes, including the E0 extended prefix.
//   Drives the key-event inputs of the Tetris VGA game logic: the 16-bit key code,
//   the key-pressed strobe and the per-arrow strobes (E06B left, E074 right,
//   E075 up/rotate, E072 down).
// PARAMETERS
//   SYNC_STAGES   2      synchroniser flops on iPS2_CLK and iPS2_DAT (min 2)
//   FILTER_LEN    4      consecutive equal samples needed before filtered PS/2 clock changes
//   TIMEOUT_CYC   50000  iCLK cycles without a PS/2 falling edge that aborts a partial frame
//   FIFO_DEPTH    4      raw-byte FIFO entries; power of 2; used only with the FIFO macro
// PORTS
//   iCLK          in   1   system clock, all logic on posedge
//   iRST_n        in   1   asynchronous active-low reset
//   iPS2_CLK      in   1   raw PS/2 clock, asynchronous
//   iPS2_DAT      in   1   raw PS/2 data, asynchronous
//   oKEY_PRESSED  out  1   1-cycle strobe per completed make code
//   oKEY_CODE     out  16  last make code: {8'hE0 or 8'h00, code}; held until next make
//   oUP           out  1   1-cycle strobe on make E075
//   oDOWN         out  1   1-cycle strobe on make E072
//   oLEFT         out  1   1-cycle strobe on make E06B
//   oRIGHT        out  1   1-cycle strobe on make E074
//   oHELD         out  4   level per arrow: [3] up, [2] down, [1] left, [0] right
//   oFRAME_ERR    out  1   1-cycle strobe on parity, stop or timeout error
//   oBYTE         out  8   FIFO head byte (PS2_RX_FIFO_EN only)
//   oBYTE_VALID   out  1   FIFO non-empty (PS2_RX_FIFO_EN only)
//   iBYTE_READY   in   1   pop FIFO when oBYTE_VALID & iBYTE_READY (PS2_RX_FIFO_EN only)
//   oFIFO_OVF     out  1   1-cycle strobe when a byte is dropped on full (PS2_RX_FIFO_EN only)
// BEHAVIOUR
//   Reset
//     All outputs 0.
//     Frame FSM goes to IDLE; ext/brk flags, timeout counter and FIFO are cleared.
//     Filtered clock and data reset to 1.
//     Reset mid-frame discards the partial frame.
//   Front end
//     Each input passes SYNC_STAGES flops, then a FILTER_LEN-sample filter.
//     A sample event is a 1->0 transition of the filtered clock.
//     Data is sampled on the filtered data value in that same cycle.
//   Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE
//     IDLE: sample with data=0 -> DATA, bit count 0; data=1 is ignored.
//     DATA: shift in LSB first; after 8 samples -> PARITY.
//     PARITY: store the bit; frame requires odd parity over 8 data bits + parity bit.
//     STOP: data=1 and parity OK -> byte_valid for 1 cycle; otherwise oFRAME_ERR.
//           Both cases return to IDLE.
//     Timeout: counter clears on every sample event and on IDLE.
//           Outside IDLE, when the count reaches TIMEOUT_CYC-1: oFRAME_ERR, -> IDLE.
//   Decoder (acts on byte_valid)
//     E0 -> ext=1; F0 -> brk=1; no outputs for either.
//     Repeated prefixes keep the flag set.
//     Any other byte (including E1, AA, FA) is a code.
//     Code with brk=1: clear the matching oHELD bit if ext & arrow; no strobes.
//     Code with brk=0: oKEY_PRESSED=1, oKEY_CODE={ext?8'hE0:8'h00, byte}.
//       If ext & arrow: set the matching arrow strobe and oHELD bit.
//     ext and brk clear after every code byte and on oFRAME_ERR.
//     Typematic repeats of a make re-issue the strobes.
//     Non-extended 6B/74/75/72 (keypad) are NOT arrows.
//   Latency
//     oKEY_PRESSED and arrow strobes are registered.
//     They assert exactly 2 iCLK cycles after the cycle in which the stop-bit sample event occurs.
//     Strobes never coincide with oFRAME_ERR.
//   Width rules
//     Bit counter 3 bits.
//     Timeout counter is $clog2(TIMEOUT_CYC) bits and saturates at the limit.
// CONFIGURATION
//   PS2_RX_FIFO_EN defined:
//     Every valid byte, prefixes included, is pushed into a FIFO_DEPTH-entry FIFO.
//     oBYTE/oBYTE_VALID show the head with first-word fall-through.
//     Push and pop in the same cycle when full is accepted, with no drop.
//     Push when full and no pop: the byte is dropped and oFIFO_OVF pulses.
//     The decoder runs independently of FIFO state.
//   PS2_RX_FIFO_EN undefined:
//     FIFO ports are absent from the port list; decoder outputs are unchanged.
// TESTING
//   Frame 0x1C, odd parity 0, stop 1:
//     -> oKEY_PRESSED 1 cycle, oKEY_CODE=16'h001C, no arrow strobe, oHELD=0.
//   Bytes E0,6B:
//     -> oLEFT and oKEY_PRESSED 1 cycle, oKEY_CODE=16'hE06B, oHELD=4'b0010.
//   Then E0,F0,6B:
//     -> oHELD=0, no strobes, oKEY_CODE stays 16'hE06B.
//   Frame 0x74 with wrong parity:
//     -> oFRAME_ERR 1 cycle, no strobes.
//   Then E0,74:
//     -> oRIGHT, oKEY_CODE=16'hE074.
//   Start bit + 5 data bits, then silence:
//     -> oFRAME_ERR exactly TIMEOUT_CYC cycles after the last edge; next frame 0x1C decodes.
//   iPS2_CLK low glitch lasting FILTER_LEN-1 cycles mid-frame:
//     -> no sample; frame 0x75 after E0 still gives oUP.
//   With PS2_RX_FIFO_EN, iBYTE_READY=0, send 5 bytes:
//     -> 4 held in order, oFIFO_OVF on the 5th.
//   Assert iRST_n=0 mid-frame:
//     -> all outputs 0 immediately; next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver: framing, make/break/E0 decode, arrow strobes; optional raw-byte FIFO under PS2_RX_FIFO_EN
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iPS2_CLK,
    input  logic        iPS2_DAT,
    output logic        oKEY_PRESSED,
    output logic [15:0] oKEY_CODE,
    output logic        oUP,
    output logic        oDOWN,
    output logic        oLEFT,
    output logic        oRIGHT,
    output logic [3:0]  oHELD,
    output logic        oFRAME_ERR
`ifdef PS2_RX_FIFO_EN
    ,
    output logic [7:0]  oBYTE,
    output logic        oBYTE_VALID,
    input  logic        iBYTE_READY,
    output logic        oFIFO_OVF
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    // The abort is registered, so it is armed one count early to land as the counter reaches TO_LAST.
    localparam logic [TO_W-1:0] TO_ARM  = TO_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FILTER_LEN-1:0]  clk_hist;
    logic [FILTER_LEN-1:0]  dat_hist;
    logic                   clk_filt;
    logic                   dat_filt;
    logic                   clk_filt_d;
    logic                   sample_evt;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_byte;
    logic                   par_bit;
    logic                   byte_valid;
    logic                   frame_err;
    logic [TO_W-1:0]        to_cnt;

    logic                   ext_flag;
    logic                   brk_flag;
    logic [3:0]             arrow_sel;

    // Synchronise the raw PS/2 lines into the iCLK domain; idle level is 1.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], iPS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], iPS2_DAT};
        end
    end

    // Filtered lines only change after FILTER_LEN identical samples; shorter pulses are ignored.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_hist   <= '1;
            dat_hist   <= '1;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[SYNC_STAGES-1]};
            dat_hist   <= {dat_hist[FILTER_LEN-2:0], dat_sync[SYNC_STAGES-1]};
            if (&clk_hist)       clk_filt <= 1'b1;
            else if (~|clk_hist) clk_filt <= 1'b0;
            if (&dat_hist)       dat_filt <= 1'b1;
            else if (~|dat_hist) dat_filt <= 1'b0;
            clk_filt_d <= clk_filt;
        end
    end

    assign sample_evt = clk_filt_d & ~clk_filt;

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; aborts on a stalled PS/2 clock.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            rx_byte    <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_IDLE || sample_evt) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (sample_evt && !dat_filt) begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (sample_evt) begin
                        rx_byte <= {dat_filt, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (sample_evt) begin
                        par_bit <= dat_filt;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_evt) begin
                        if (dat_filt && (^{rx_byte, par_bit})) byte_valid <= 1'b1;
                        else                                   frame_err  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (state != S_IDLE && !sample_evt && to_cnt == TO_ARM) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
            end
        end
    end

    assign oFRAME_ERR = frame_err;

    // One-hot arrow select for the received byte, in oHELD bit order (up, down, left, right).
    always_comb begin
        arrow_sel = 4'b0000;
        case (rx_byte)
            8'h75:   arrow_sel = 4'b1000;
            8'h72:   arrow_sel = 4'b0100;
            8'h6B:   arrow_sel = 4'b0010;
            8'h74:   arrow_sel = 4'b0001;
            default: arrow_sel = 4'b0000;
        endcase
    end

    // Scan-code decoder: prefixes set flags, codes produce make strobes or clear held arrows on break.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            oKEY_PRESSED <= 1'b0;
            oKEY_CODE    <= 16'h0000;
            oUP          <= 1'b0;
            oDOWN        <= 1'b0;
            oLEFT        <= 1'b0;
            oRIGHT       <= 1'b0;
            oHELD        <= 4'b0000;
        end else begin
            oKEY_PRESSED <= 1'b0;
            oUP          <= 1'b0;
            oDOWN        <= 1'b0;
            oLEFT        <= 1'b0;
            oRIGHT       <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (brk_flag) begin
                        if (ext_flag) oHELD <= oHELD & ~arrow_sel;
                    end else begin
                        oKEY_PRESSED <= 1'b1;
                        oKEY_CODE    <= {(ext_flag ? 8'hE0 : 8'h00), rx_byte};
                        if (ext_flag) begin
                            oHELD                      <= oHELD | arrow_sel;
                            {oUP, oDOWN, oLEFT, oRIGHT} <= arrow_sel;
                        end
                    end
                end
            end
        end
    end

`ifdef PS2_RX_FIFO_EN
    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_push;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign fifo_pop   = !fifo_empty && iBYTE_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign fifo_push  = byte_valid && (!fifo_full || fifo_pop);

    // Raw-byte FIFO with first-word fall-through; drops and flags bytes that arrive when full.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oFIFO_OVF <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
        end else begin
            oFIFO_OVF <= byte_valid && fifo_full && !fifo_pop;
            if (fifo_push) begin
                fifo_mem[wr_ptr[FIFO_AW-1:0]] <= rx_byte;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign oBYTE       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign oBYTE_VALID = !fifo_empty;
`else
    // FIFO_DEPTH only sizes the FIFO build.
    if (FIFO_DEPTH < 1) begin : g_no_fifo
    end
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

    localparam int S   = 2;
    localparam int F   = 4;
    localparam int T   = 300;
    localparam int EVT = 1 + S + F;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iPS2_CLK;
    logic        iPS2_DAT;
    logic        oKEY_PRESSED;
    logic [15:0] oKEY_CODE;
    logic        oUP, oDOWN, oLEFT, oRIGHT;
    logic [3:0]  oHELD;
    logic        oFRAME_ERR;
`ifdef PS2_RX_FIFO_EN
    logic [7:0]  oBYTE;
    logic        oBYTE_VALID;
    logic        iBYTE_READY;
    logic        oFIFO_OVF;
`endif

    ps2_keyboard_rx #(
        .SYNC_STAGES(S),
        .FILTER_LEN (F),
        .TIMEOUT_CYC(T),
        .FIFO_DEPTH (4)
    ) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iPS2_CLK    (iPS2_CLK),
        .iPS2_DAT    (iPS2_DAT),
        .oKEY_PRESSED(oKEY_PRESSED),
        .oKEY_CODE   (oKEY_CODE),
        .oUP         (oUP),
        .oDOWN       (oDOWN),
        .oLEFT       (oLEFT),
        .oRIGHT      (oRIGHT),
        .oHELD       (oHELD),
        .oFRAME_ERR  (oFRAME_ERR)
`ifdef PS2_RX_FIFO_EN
        ,
        .oBYTE       (oBYTE),
        .oBYTE_VALID (oBYTE_VALID),
        .iBYTE_READY (iBYTE_READY),
        .oFIFO_OVF   (oFIFO_OVF)
`endif
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // observed strobe activity
    int n_press = 0, n_up = 0, n_down = 0, n_left = 0, n_right = 0, n_err = 0;
    int n_ovf = 0, n_wide = 0, n_coinc = 0, press_cyc = -1;
    logic [5:0] prev_strb = 6'b0;
    logic [5:0] cur_strb;

    always @(negedge iCLK) begin
        cur_strb = {oKEY_PRESSED, oUP, oDOWN, oLEFT, oRIGHT, oFRAME_ERR};
        if (iRST_n) begin
            if (oKEY_PRESSED) begin n_press++; press_cyc = cyc; end
            if (oUP)    n_up++;
            if (oDOWN)  n_down++;
            if (oLEFT)  n_left++;
            if (oRIGHT) n_right++;
            if (oFRAME_ERR) n_err++;
`ifdef PS2_RX_FIFO_EN
            if (oFIFO_OVF) n_ovf++;
`endif
            if ((cur_strb & prev_strb) != 6'b0) n_wide++;
            if (oFRAME_ERR && (cur_strb[5:1] != 5'b0)) n_coinc++;
        end
        prev_strb = cur_strb;
    end

    // reference model: byte-level keyboard protocol rules
    logic        m_ext = 1'b0, m_brk = 1'b0;
    logic [3:0]  m_held = 4'b0;
    logic [15:0] m_code = 16'h0;
    int m_press = 0, m_up = 0, m_down = 0, m_left = 0, m_right = 0, m_err = 0;

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [3:0] sel;
        sel = 4'b0;
        if (!ok) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_ext) begin
                if (b == 8'h75) sel = 4'b1000;
                if (b == 8'h72) sel = 4'b0100;
                if (b == 8'h6B) sel = 4'b0010;
                if (b == 8'h74) sel = 4'b0001;
            end
            if (m_brk) begin
                m_held = m_held & ~sel;
            end else begin
                m_press++;
                m_code  = {(m_ext ? 8'hE0 : 8'h00), b};
                m_held  = m_held | sel;
                m_up    += int'(sel[3]);
                m_down  += int'(sel[2]);
                m_left  += int'(sel[1]);
                m_right += int'(sel[0]);
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // PS/2 device driver
    int hp = 8;
    int last_fall = 0;

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge iCLK);
        iPS2_DAT = b;
        if (glitch) begin
            repeat (2) @(negedge iCLK);
            iPS2_CLK = 1'b0;
            repeat (F - 1) @(negedge iCLK);
            iPS2_CLK = 1'b1;
            repeat (hp - 2 - (F - 1)) @(negedge iCLK);
        end else begin
            repeat (hp) @(negedge iCLK);
        end
        iPS2_CLK  = 1'b0;
        last_fall = cyc;
        repeat (hp) @(negedge iCLK);
        iPS2_CLK = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    task automatic ps2_frame(input logic [7:0] b, input int kind, input int glitch_bit);
        logic [10:0] f;
        f = {(kind != 2), ((~^b) ^ (kind == 1)), b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
        @(negedge iCLK);
        iPS2_DAT = 1'b1;
        repeat (4 * hp) @(negedge iCLK);
    endtask

    task automatic send(input logic [7:0] b, input int kind);
        ps2_frame(b, kind, -1);
        model_byte(b, kind == 0);
    endtask

    task automatic test_reset();
        iRST_n   = 1'b0;
        iPS2_CLK = 1'b1;
        iPS2_DAT = 1'b1;
        #1;
        n_tests++;
        if ({oKEY_PRESSED, oKEY_CODE, oUP, oDOWN, oLEFT, oRIGHT, oHELD, oFRAME_ERR} !== 26'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got code=%h held=%b strobes=%b, need all 0",
                     oKEY_CODE, oHELD, {oKEY_PRESSED, oUP, oDOWN, oLEFT, oRIGHT, oFRAME_ERR});
        end
`ifdef PS2_RX_FIFO_EN
        n_tests++;
        if ({oBYTE, oBYTE_VALID, oFIFO_OVF} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_fifo: got byte=%h valid=%b ovf=%b, need 0", oBYTE, oBYTE_VALID, oFIFO_OVF);
        end
`endif
        repeat (5) @(negedge iCLK);
        iRST_n = 1'b1;
        repeat (5) @(negedge iCLK);
    endtask

    task automatic test_single_make();
        int p0;
        p0 = n_press;
        send(8'h1C, 0);
        n_tests++;
        if (n_press !== p0 + 1) begin n_fail++; $display("FAIL make_1c_press: got %0d pulses, need 1", n_press - p0); end
        n_tests++;
        if (oKEY_CODE !== 16'h001C) begin n_fail++; $display("FAIL make_1c_code: got %h, need 001c", oKEY_CODE); end
        n_tests++;
        if ({n_up, n_down, n_left, n_right} !== 128'b0 || oHELD !== 4'b0) begin
            n_fail++; $display("FAIL make_1c_arrows: got arrows %0d/%0d/%0d/%0d held %b, need none", n_up, n_down, n_left, n_right, oHELD);
        end
        n_tests++;
        if (press_cyc !== last_fall + EVT + 2) begin
            n_fail++; $display("FAIL make_latency: got press at cycle %0d, need %0d", press_cyc, last_fall + EVT + 2);
        end
    endtask

    task automatic test_ext_arrow();
        int l0, p0;
        l0 = n_left; p0 = n_press;
        send(8'hE0, 0);
        send(8'h6B, 0);
        n_tests++;
        if (n_left !== l0 + 1 || n_press !== p0 + 1) begin
            n_fail++; $display("FAIL e06b_strobes: got left %0d press %0d, need 1 and 1", n_left - l0, n_press - p0);
        end
        n_tests++;
        if (oKEY_CODE !== 16'hE06B) begin n_fail++; $display("FAIL e06b_code: got %h, need e06b", oKEY_CODE); end
        n_tests++;
        if (oHELD !== 4'b0010) begin n_fail++; $display("FAIL e06b_held: got %b, need 0010", oHELD); end
    endtask

    task automatic test_break();
        int p0;
        p0 = n_press;
        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h6B, 0);
        n_tests++;
        if (oHELD !== 4'b0000) begin n_fail++; $display("FAIL break_held: got %b, need 0000", oHELD); end
        n_tests++;
        if (n_press !== p0) begin n_fail++; $display("FAIL break_press: got %0d pulses, need 0", n_press - p0); end
        n_tests++;
        if (oKEY_CODE !== 16'hE06B) begin n_fail++; $display("FAIL break_code: got %h, need e06b", oKEY_CODE); end
    endtask

    task automatic test_parity_err();
        int e0, p0, r0;
        e0 = n_err; p0 = n_press;
        send(8'h74, 1);
        n_tests++;
        if (n_err !== e0 + 1 || n_press !== p0) begin
            n_fail++; $display("FAIL parity_err: got err %0d press %0d, need 1 and 0", n_err - e0, n_press - p0);
        end
        r0 = n_right;
        send(8'hE0, 0);
        send(8'h74, 0);
        n_tests++;
        if (n_right !== r0 + 1 || oKEY_CODE !== 16'hE074) begin
            n_fail++; $display("FAIL after_err_e074: got right %0d code %h, need 1 and e074", n_right - r0, oKEY_CODE);
        end
        r0 = n_right; e0 = n_err;
        send(8'hE0, 0);
        send(8'h55, 2);
        send(8'h74, 0);
        n_tests++;
        if (n_err !== e0 + 1 || n_right !== r0 || oKEY_CODE !== 16'h0074) begin
            n_fail++; $display("FAIL stop_err_clears_ext: got err %0d right %0d code %h, need 1, 0, 0074", n_err - e0, n_right - r0, oKEY_CODE);
        end
        n_tests++;
        if (oHELD !== m_held) begin n_fail++; $display("FAIL parity_held: got %b, need %b", oHELD, m_held); end
    endtask

    task automatic test_timeout();
        int got;
        got = -1;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < T + 50 && got < 0; i++) begin
            @(negedge iCLK);
            if (oFRAME_ERR) got = cyc;
        end
        model_byte(8'h00, 1'b0);
        n_tests++;
        if (got !== last_fall + EVT + T) begin
            n_fail++; $display("FAIL timeout_cycle: got error at cycle %0d, need %0d", got, last_fall + EVT + T);
        end
        repeat (20) @(negedge iCLK);
        send(8'h1C, 0);
        n_tests++;
        if (oKEY_CODE !== 16'h001C || n_press !== m_press) begin
            n_fail++; $display("FAIL timeout_recover: got code %h presses %0d, need 001c and %0d", oKEY_CODE, n_press, m_press);
        end
    endtask

    task automatic test_glitch();
        int u0;
        u0 = n_up;
        hp = 10;
        send(8'hE0, 0);
        ps2_frame(8'h75, 0, 4);
        model_byte(8'h75, 1'b1);
        n_tests++;
        if (n_up !== u0 + 1) begin n_fail++; $display("FAIL glitch_up: got %0d up pulses, need 1", n_up - u0); end
        n_tests++;
        if (oKEY_CODE !== 16'hE075) begin n_fail++; $display("FAIL glitch_code: got %h, need e075", oKEY_CODE); end
        n_tests++;
        if (oHELD !== m_held) begin n_fail++; $display("FAIL glitch_held: got %b, need %b", oHELD, m_held); end
        hp = 8;
    endtask

    task automatic test_reset_mid();
        int l0;
        send(8'hE0, 0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge iCLK);
        iRST_n = 1'b0;
        #1;
        n_tests++;
        if ({oKEY_PRESSED, oKEY_CODE, oUP, oDOWN, oLEFT, oRIGHT, oHELD, oFRAME_ERR} !== 26'b0) begin
            n_fail++; $display("FAIL midframe_reset: got code=%h held=%b, need all 0", oKEY_CODE, oHELD);
        end
        m_ext = 1'b0; m_brk = 1'b0; m_held = 4'b0; m_code = 16'h0;
        repeat (4) @(negedge iCLK);
        iRST_n   = 1'b1;
        iPS2_DAT = 1'b1;
        repeat (10) @(negedge iCLK);
        l0 = n_left;
        send(8'h6B, 0);
        n_tests++;
        if (oKEY_CODE !== 16'h006B || n_left !== l0) begin
            n_fail++; $display("FAIL after_reset_decode: got code %h left %0d, need 006b and 0", oKEY_CODE, n_left - l0);
        end
        n_tests++;
        if (oHELD !== 4'b0) begin n_fail++; $display("FAIL after_reset_held: got %b, need 0000", oHELD); end
    endtask

`ifdef PS2_RX_FIFO_EN
    task automatic test_fifo();
        logic [7:0] b [5];
        int o0;
        iBYTE_READY = 1'b0;
        o0 = n_ovf;
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            send(b[i], 0);
            if (i == 3) begin
                n_tests++;
                if (n_ovf !== o0) begin n_fail++; $display("FAIL fifo_early_ovf: got %0d, need 0", n_ovf - o0); end
            end
        end
        n_tests++;
        if (n_ovf !== o0 + 1) begin n_fail++; $display("FAIL fifo_ovf: got %0d, need 1", n_ovf - o0); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (oBYTE_VALID !== 1'b1 || oBYTE !== b[i]) begin
                n_fail++; $display("FAIL fifo_order[%0d]: got valid %b byte %h, need 1 and %h", i, oBYTE_VALID, oBYTE, b[i]);
            end
            iBYTE_READY = 1'b1;
            @(negedge iCLK);
            iBYTE_READY = 1'b0;
        end
        n_tests++;
        if (oBYTE_VALID !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: got valid %b, need 0", oBYTE_VALID); end
        iBYTE_READY = 1'b1;
    endtask
`endif

    task automatic test_random();
        logic [7:0] b;
        int r, kind;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3:       b = 8'h75;
                4:       b = 8'h72;
                5:       b = 8'h6B;
                6:       b = 8'h74;
                default: b = 8'($urandom);
            endcase
            if (r > 6 && (b == 8'hE0 || b == 8'hF0)) b = 8'h1C;
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            hp   = int'($urandom_range(6, 12));
            send(b, kind);
            n_tests++;
            if ({n_press, n_up, n_down, n_left, n_right, n_err} !== {m_press, m_up, m_down, m_left, m_right, m_err}) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got press/u/d/l/r/err %0d/%0d/%0d/%0d/%0d/%0d, need %0d/%0d/%0d/%0d/%0d/%0d",
                         n, n_press, n_up, n_down, n_left, n_right, n_err, m_press, m_up, m_down, m_left, m_right, m_err);
            end
            n_tests++;
            if (oKEY_CODE !== m_code) begin n_fail++; $display("FAIL rand_code[%0d]: got %h, need %h", n, oKEY_CODE, m_code); end
            n_tests++;
            if (oHELD !== m_held) begin n_fail++; $display("FAIL rand_held[%0d]: got %b, need %b", n, oHELD, m_held); end
        end
        hp = 8;
    endtask

    initial begin
`ifdef PS2_RX_FIFO_EN
        iBYTE_READY = 1'b1;
`endif
        test_reset();
        test_single_make();
        test_ext_arrow();
        test_break();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
`ifdef PS2_RX_FIFO_EN
        test_fifo();
`endif
        test_random();
        n_tests++;
        if (n_wide !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d multi-cycle strobes, need 0", n_wide); end
        n_tests++;
        if (n_coinc !== 0) begin n_fail++; $display("FAIL strobe_vs_err: got %0d coincidences, need 0", n_coinc); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
